// File: rtl/button_event.sv
// button_event: turns a clean button level into press/release/long/repeat
// strobes, plus a held level and a wrapping press counter.
module button_event #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    input  logic             clr_count,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] press_count
);

    localparam int MAX_C =
        (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int TW = $clog2(MAX_C);

    localparam logic [TW-1:0] LONG_END = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] REP_END  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          btn_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            btn_prev      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= '0;
        end else begin
            btn_prev      <= btn_in;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (clr_count)
                press_count <= '0;

            unique case (state)
                IDLE: begin
                    if (btn_in && !btn_prev) begin
                        state       <= HELD;
                        held        <= 1'b1;
                        timer       <= '0;
                        press_pulse <= 1'b1;
                        // a coincident clear lands first, so the count reads 1
                        press_count <= (clr_count ? '0 : press_count)
                                       + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_in) begin
                        state         <= IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                        timer         <= '0;
                    end else if (timer == LONG_END) begin
                        state      <= REPEAT;
                        long_pulse <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!btn_in) begin
                        state         <= IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                        timer         <= '0;
                    end else if (timer == REP_END) begin
                        repeat_pulse <= 1'b1;
                        timer        <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: vector table, directed corner sequences and a random
// run compared against a hold-age reference model.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_in = 1'b0;
    logic         clr_count = 1'b0;
    logic         press_pulse;
    logic         release_pulse;
    logic         long_pulse;
    logic         repeat_pulse;
    logic         held;
    logic [W-1:0] press_count;

    button_event #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .clr_count    (clr_count),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: tracks how many edges the button has been held
    bit m_held, m_prev;
    int m_age, m_cnt;
    bit e_press, e_rel, e_long, e_rep;

    task automatic model_edge(input bit r, input bit b, input bit c);
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        if (!r) begin
            m_held = 0; m_prev = 0; m_age = 0; m_cnt = 0;
        end else begin
            if (c) m_cnt = 0;
            if (!m_held) begin
                if (b && !m_prev) begin
                    m_held = 1; m_age = 0; e_press = 1;
                    m_cnt = (m_cnt + 1) % (1 << W);
                end
            end else if (!b) begin
                m_held = 0; e_rel = 1;
            end else begin
                m_age++;
                if (m_age == L) e_long = 1;
                else if (m_age > L && (m_age - L) % R == 0) e_rep = 1;
            end
            m_prev = b;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit b, input bit c);
        rst_n = r; btn_in = b; clr_count = c;
        @(posedge clk);
        model_edge(r, b, c);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".press"}, int'(press_pulse), int'(e_press));
        check({tag, ".release"}, int'(release_pulse), int'(e_rel));
        check({tag, ".long"}, int'(long_pulse), int'(e_long));
        check({tag, ".repeat"}, int'(repeat_pulse), int'(e_rep));
        check({tag, ".held"}, int'(held), int'(m_held));
        check({tag, ".count"}, int'(press_count), m_cnt);
        check({tag, ".onehot"},
              int'(press_pulse) + int'(release_pulse) +
              int'(long_pulse) + int'(repeat_pulse) <= 1 ? 1 : 0, 1);
    endtask

    typedef struct {
        bit       r, b, c;
        bit       p, rl, lg, rp, h;
        bit [3:0] cnt;
    } vec_t;

    vec_t vt[13];
    int long_at, first_rep, last_rep, rep_n;
    int run_left;
    bit rb, rr, rc;

    initial begin
        //       r  b  c  p rl lg rp  h cnt
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{1, 1, 0, 1, 0, 0, 0, 1, 1};
        vt[4]  = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        vt[5]  = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        vt[6]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        vt[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[8]  = '{1, 1, 0, 1, 0, 0, 0, 1, 2};
        vt[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 2};
        vt[10] = '{1, 1, 0, 1, 0, 0, 0, 1, 3};
        vt[11] = '{1, 0, 0, 0, 1, 0, 0, 0, 3};
        vt[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            step(vt[i].r, vt[i].b, vt[i].c);
            check($sformatf("vec%0d.press", i), int'(press_pulse), int'(vt[i].p));
            check($sformatf("vec%0d.release", i), int'(release_pulse), int'(vt[i].rl));
            check($sformatf("vec%0d.long", i), int'(long_pulse), int'(vt[i].lg));
            check($sformatf("vec%0d.repeat", i), int'(repeat_pulse), int'(vt[i].rp));
            check($sformatf("vec%0d.held", i), int'(held), int'(vt[i].h));
            check($sformatf("vec%0d.count", i), int'(press_count), int'(vt[i].cnt));
        end

        // long hold: 30 cycles high
        long_at = -1; first_rep = -1; last_rep = -1; rep_n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0);
            check_model("hold");
            if (long_pulse) long_at = i;
            if (repeat_pulse) begin
                if (first_rep < 0) first_rep = i;
                last_rep = i;
                rep_n++;
            end
        end
        check("hold.long_at", long_at, 8);
        check("hold.first_rep", first_rep, 12);
        check("hold.last_rep", last_rep, 28);
        check("hold.rep_n", rep_n, 5);
        step(1, 0, 0);
        check("hold.release", int'(release_pulse), 1);
        check_model("hold_rel");

        // threshold race: first low sample on P+8
        step(1, 1, 0);
        check("race.press", int'(press_pulse), 1);
        for (int i = 1; i < 8; i++) begin
            step(1, 1, 0);
            check_model("race");
        end
        step(1, 0, 0);
        check("race.release", int'(release_pulse), 1);
        check("race.long", int'(long_pulse), 0);
        check("race.held", int'(held), 0);
        step(1, 0, 0);
        check("race.long_after", int'(long_pulse), 0);

        // wrap and clear
        step(1, 0, 1);
        check("wrap.clr", int'(press_count), 0);
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 0);
            check_model("tap");
            step(1, 0, 0);
            check_model("tap_rel");
        end
        check("wrap.count", int'(press_count), 1);
        step(1, 1, 1);
        check("wrap.clr_press", int'(press_count), 1);
        check_model("clr_press");
        step(1, 0, 0);
        step(1, 0, 1);
        check("wrap.clr_alone", int'(press_count), 0);

        // reset during REPEAT, button held through reset
        for (int i = 0; i < 14; i++) begin
            step(1, 1, 0);
            check_model("pre_rst");
        end
        step(0, 1, 0);
        check("rst.release", int'(release_pulse), 0);
        check("rst.held", int'(held), 0);
        check_model("rst");
        step(1, 1, 0);
        check("rst.press_after", int'(press_pulse), 1);
        check_model("rst_after");
        step(1, 0, 0);
        check_model("rst_after_rel");

        // randomized run-length stimulus
        run_left = 0; rb = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                rb = ~rb;
                run_left = (($urandom % 4) == 0) ? int'($urandom_range(9, 30))
                                                 : int'($urandom_range(1, 6));
            end
            run_left--;
            rr = ($urandom % 300) != 0;
            rc = ($urandom % 20) == 0;
            step(rr, rb, rc);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
